// File: rtl/autoanim_multi.sv
// autoanim_multi: bank of independent sprite auto-animation sequencers.
//
// Each channel runs a SPEED_W-bit down-counting prescaler that is clocked by
// the CE timebase strobe. On terminal count it fires a one-clock tick and
// advances a COUNT_W-bit tile counter according to its mode (loop, ping-pong,
// one-shot or hold) and programmable end value.
//
// Ports:
//   CLK       system clock, rising-edge
//   RESETP    asynchronous active-low reset
//   CE        timebase enable; prescalers only advance when high
//   AA_EN     per-channel enable; low freezes that channel
//   AA_SYNC   per-channel synchronous restart strobe
//   AA_SPEED  packed periods, channel n at [n*SPEED_W +: SPEED_W]
//   AA_LIMIT  packed end values, channel n at [n*COUNT_W +: COUNT_W]
//   AA_MODE   packed modes (0 loop, 1 ping-pong, 2 one-shot, 3 hold)
//   AA_COUNT  packed registered tile counters
//   AA_TICK   registered one-clock pulse per counter update
//   AA_DONE   sticky one-shot complete flags
module autoanim_multi #(
  parameter int CHANNELS = 2,
  parameter int SPEED_W  = 8,
  parameter int COUNT_W  = 3
) (
  input  logic                        CLK,
  input  logic                        RESETP,
  input  logic                        CE,
  input  logic [CHANNELS-1:0]         AA_EN,
  input  logic [CHANNELS-1:0]         AA_SYNC,
  input  logic [CHANNELS*SPEED_W-1:0] AA_SPEED,
  input  logic [CHANNELS*COUNT_W-1:0] AA_LIMIT,
  input  logic [CHANNELS*2-1:0]       AA_MODE,
  output logic [CHANNELS*COUNT_W-1:0] AA_COUNT,
  output logic [CHANNELS-1:0]         AA_TICK,
  output logic [CHANNELS-1:0]         AA_DONE
);

  localparam logic [1:0] MODE_LOOP = 2'd0;
  localparam logic [1:0] MODE_PP   = 2'd1;
  localparam logic [1:0] MODE_ONE  = 2'd2;
  localparam logic [1:0] MODE_HOLD = 2'd3;

  // Ping-pong direction
  // state    | meaning
  // DIR_UP   | counting toward LIMIT
  // DIR_DOWN | counting back toward 0
  localparam logic [0:0] DIR_UP   = 1'b0;
  localparam logic [0:0] DIR_DOWN = 1'b1;

  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [SPEED_W-1:0] spd;
    logic [COUNT_W-1:0] lim;
    logic [1:0]         mode;

    logic [SPEED_W-1:0] p;
    logic [COUNT_W-1:0] cnt;
    logic [0:0]         dir;
    logic               done;
    logic               tick;

    logic [COUNT_W-1:0] cnt_inc;
    logic [COUNT_W-1:0] cnt_nxt;
    logic [0:0]         dir_nxt;
    logic               done_nxt;

    assign spd  = AA_SPEED[n*SPEED_W +: SPEED_W];
    assign lim  = AA_LIMIT[n*COUNT_W +: COUNT_W];
    assign mode = AA_MODE[n*2 +: 2];

    assign cnt_inc = cnt + CNT_ONE;

    // Next counter state, applied only on a tick event.
    always_comb begin
      cnt_nxt  = cnt;
      dir_nxt  = dir;
      done_nxt = done;
      case (mode)
        MODE_LOOP: begin
          // Dropping out of ping-pong mid-descent must not leave dir stuck down.
          dir_nxt = DIR_UP;
          cnt_nxt = (cnt < lim) ? cnt_inc : '0;
        end
        MODE_PP: begin
          if (dir == DIR_UP) begin
            if (cnt < lim) begin
              cnt_nxt = cnt_inc;
              if (cnt_inc == lim) dir_nxt = DIR_DOWN;
            end else begin
              // Also catches LIMIT lowered below the current count.
              cnt_nxt = lim;
              dir_nxt = DIR_DOWN;
            end
          end else begin
            if (cnt > CNT_ONE) begin
              cnt_nxt = cnt - CNT_ONE;
            end else begin
              cnt_nxt = '0;
              dir_nxt = DIR_UP;
            end
          end
        end
        MODE_ONE: begin
          if (!done) begin
            if (cnt < lim) begin
              cnt_nxt  = cnt_inc;
              done_nxt = (cnt_inc == lim);
            end else begin
              cnt_nxt  = lim;
              done_nxt = 1'b1;
            end
          end
        end
        MODE_HOLD: begin
          cnt_nxt = cnt;
        end
        default: begin
          cnt_nxt = cnt;
        end
      endcase
    end

    always_ff @(posedge CLK or negedge RESETP) begin
      if (!RESETP) begin
        p    <= '0;
        cnt  <= '0;
        dir  <= DIR_UP;
        done <= 1'b0;
        tick <= 1'b0;
      end else if (AA_SYNC[n]) begin
        p    <= spd;
        cnt  <= '0;
        dir  <= DIR_UP;
        done <= 1'b0;
        tick <= 1'b0;
      end else if (!AA_EN[n] || !CE) begin
        tick <= 1'b0;
      end else if (p == '0) begin
        p    <= spd;
        cnt  <= cnt_nxt;
        dir  <= dir_nxt;
        done <= done_nxt;
        tick <= 1'b1;
      end else begin
        p    <= p - 1'b1;
        tick <= 1'b0;
      end
    end

    assign AA_COUNT[n*COUNT_W +: COUNT_W] = cnt;
    assign AA_TICK[n] = tick;
    assign AA_DONE[n] = done;
  end

endmodule

// File: tb/tb_autoanim_multi.sv
module tb_autoanim_multi;

  logic       CLK;
  logic       RESETP;
  logic       CE;
  logic [1:0] AA_EN;
  logic [1:0] AA_SYNC;
  logic [15:0] AA_SPEED;
  logic [5:0] AA_LIMIT;
  logic [3:0] AA_MODE;
  logic [5:0] AA_COUNT;
  logic [1:0] AA_TICK;
  logic [1:0] AA_DONE;

  logic [7:0] spd0, spd1;
  logic [2:0] lim0, lim1;
  logic [1:0] mode0, mode1;
  logic [2:0] c0, c1;

  int checks = 0;
  int errors = 0;

  assign AA_SPEED = {spd1, spd0};
  assign AA_LIMIT = {lim1, lim0};
  assign AA_MODE  = {mode1, mode0};
  assign c0 = AA_COUNT[2:0];
  assign c1 = AA_COUNT[5:3];

  autoanim_multi #(.CHANNELS(2), .SPEED_W(8), .COUNT_W(3)) dut (
    .CLK(CLK), .RESETP(RESETP), .CE(CE),
    .AA_EN(AA_EN), .AA_SYNC(AA_SYNC),
    .AA_SPEED(AA_SPEED), .AA_LIMIT(AA_LIMIT), .AA_MODE(AA_MODE),
    .AA_COUNT(AA_COUNT), .AA_TICK(AA_TICK), .AA_DONE(AA_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Called 1 time unit after a rising edge, so the pulse never straddles one.
  task automatic do_reset();
    CE = 0; AA_EN = 2'b00; AA_SYNC = 2'b00;
    spd0 = 0; spd1 = 0; lim0 = 0; lim1 = 0; mode0 = 0; mode1 = 0;
    RESETP = 0;
    #2;
    RESETP = 1;
  endtask

  task automatic test_reset();
    RESETP = 0; CE = 1; AA_EN = 2'b11; AA_SYNC = 2'b00;
    spd0 = 0; spd1 = 0; lim0 = 7; lim1 = 7; mode0 = 0; mode1 = 0;
    cyc(); cyc();
    checks++;
    if (AA_COUNT !== 6'd0 || AA_TICK !== 2'b00 || AA_DONE !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: count=%h tick=%b done=%b want 0/00/00", AA_COUNT, AA_TICK, AA_DONE);
    end
  endtask

  task automatic test_loop();
    int exp_cnt[10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
    int j = 0;
    logic exp_tick;
    do_reset();
    spd0 = 3; lim0 = 7; mode0 = 0; AA_EN = 2'b01; CE = 1;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      exp_tick = ((k - 1) % 4 == 0);
      if (exp_tick) j++;
      checks++;
      if (AA_TICK[0] !== exp_tick) begin
        errors++;
        $display("FAIL loop_tick ce=%0d: got %b want %b", k, AA_TICK[0], exp_tick);
      end
      checks++;
      if (c0 !== 3'(exp_cnt[j-1])) begin
        errors++;
        $display("FAIL loop_count ce=%0d: got %0d want %0d", k, c0, exp_cnt[j-1]);
      end
    end
    checks++;
    if (c1 !== 3'd0 || AA_TICK[1] !== 1'b0) begin
      errors++;
      $display("FAIL loop_ch1_idle: count=%0d tick=%b want 0/0", c1, AA_TICK[1]);
    end
  endtask

  task automatic test_pingpong();
    int exp_pp[9]   = '{1, 2, 3, 2, 1, 0, 1, 2, 3};
    int exp_loop[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    do_reset();
    spd1 = 0; lim1 = 3; mode1 = 1;
    spd0 = 0; lim0 = 7; mode0 = 0;
    AA_EN = 2'b11; CE = 1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      checks++;
      if (c1 !== 3'(exp_pp[i]) || AA_TICK[1] !== 1'b1) begin
        errors++;
        $display("FAIL pingpong step=%0d: count=%0d tick=%b want %0d/1", i, c1, AA_TICK[1], exp_pp[i]);
      end
      checks++;
      if (c0 !== 3'(exp_loop[i]) || AA_TICK[0] !== 1'b1) begin
        errors++;
        $display("FAIL pp_loop_ch0 step=%0d: count=%0d tick=%b want %0d/1", i, c0, AA_TICK[0], exp_loop[i]);
      end
    end
  endtask

  task automatic test_oneshot_sync();
    int j = 0;
    logic exp_tick;
    logic [2:0] exp_c;
    do_reset();
    spd0 = 1; lim0 = 4; mode0 = 2; AA_EN = 2'b01; CE = 1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      exp_tick = (k % 2 == 1);
      if (exp_tick) j++;
      exp_c = (j >= 4) ? 3'd4 : 3'(j);
      checks++;
      if (AA_TICK[0] !== exp_tick || c0 !== exp_c || AA_DONE[0] !== (j >= 4)) begin
        errors++;
        $display("FAIL oneshot ce=%0d: tick=%b count=%0d done=%b want %b/%0d/%b",
                 k, AA_TICK[0], c0, AA_DONE[0], exp_tick, exp_c, (j >= 4));
      end
    end
    // Prescaler is at 0 here, so this edge would have ticked.
    AA_SYNC = 2'b01;
    cyc();
    AA_SYNC = 2'b00;
    checks++;
    if (c0 !== 3'd0 || AA_TICK[0] !== 1'b0 || AA_DONE[0] !== 1'b0) begin
      errors++;
      $display("FAIL sync_on_tick: count=%0d tick=%b done=%b want 0/0/0", c0, AA_TICK[0], AA_DONE[0]);
    end
    cyc();
    checks++;
    if (AA_TICK[0] !== 1'b0 || c0 !== 3'd0) begin
      errors++;
      $display("FAIL sync_reload_p: tick=%b count=%0d want 0/0", AA_TICK[0], c0);
    end
    cyc();
    checks++;
    if (AA_TICK[0] !== 1'b1 || c0 !== 3'd1 || AA_DONE[0] !== 1'b0) begin
      errors++;
      $display("FAIL sync_first_tick: tick=%b count=%0d done=%b want 1/1/0", AA_TICK[0], c0, AA_DONE[0]);
    end
  endtask

  task automatic test_enable_freeze();
    do_reset();
    spd0 = 3; lim0 = 7; mode0 = 0; AA_EN = 2'b01; CE = 1;
    for (int k = 1; k <= 6; k++) cyc();
    checks++;
    if (c0 !== 3'd2) begin
      errors++;
      $display("FAIL freeze_pre: count=%0d want 2", c0);
    end
    AA_EN = 2'b00;
    for (int k = 0; k < 10; k++) begin
      cyc();
      checks++;
      if (AA_TICK[0] !== 1'b0 || c0 !== 3'd2) begin
        errors++;
        $display("FAIL freeze_hold cyc=%0d: tick=%b count=%0d want 0/2", k, AA_TICK[0], c0);
      end
    end
    AA_EN = 2'b01;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      checks++;
      if (AA_TICK[0] !== (k == 3) || c0 !== ((k == 3) ? 3'd3 : 3'd2)) begin
        errors++;
        $display("FAIL freeze_resume ce=%0d: tick=%b count=%0d want %b/%0d",
                 k, AA_TICK[0], c0, (k == 3), (k == 3) ? 3 : 2);
      end
    end
  endtask

  task automatic test_limit_change();
    do_reset();
    spd0 = 0; lim0 = 7; mode0 = 0; AA_EN = 2'b01; CE = 1;
    for (int k = 0; k < 6; k++) cyc();
    lim0 = 2;
    cyc();
    checks++;
    if (c0 !== 3'd0) begin
      errors++;
      $display("FAIL loop_limit_drop: count=%0d want 0", c0);
    end
    do_reset();
    spd0 = 0; lim0 = 7; mode0 = 1; AA_EN = 2'b01; CE = 1;
    for (int k = 0; k < 6; k++) cyc();
    checks++;
    if (c0 !== 3'd6) begin
      errors++;
      $display("FAIL pp_limit_pre: count=%0d want 6", c0);
    end
    lim0 = 2;
    cyc();
    checks++;
    if (c0 !== 3'd2) begin
      errors++;
      $display("FAIL pp_limit_drop: count=%0d want 2", c0);
    end
    cyc();
    checks++;
    if (c0 !== 3'd1) begin
      errors++;
      $display("FAIL pp_limit_dir_down: count=%0d want 1", c0);
    end
    cyc();
    checks++;
    if (c0 !== 3'd0) begin
      errors++;
      $display("FAIL pp_limit_bottom: count=%0d want 0", c0);
    end
  endtask

  task automatic test_hold_sticky();
    do_reset();
    spd0 = 0; lim0 = 1; mode0 = 2; AA_EN = 2'b01; CE = 1;
    cyc();
    checks++;
    if (c0 !== 3'd1 || AA_DONE[0] !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_lim1: count=%0d done=%b want 1/1", c0, AA_DONE[0]);
    end
    mode0 = 3;
    for (int k = 0; k < 2; k++) begin
      cyc();
      checks++;
      if (AA_TICK[0] !== 1'b1 || c0 !== 3'd1 || AA_DONE[0] !== 1'b1) begin
        errors++;
        $display("FAIL hold cyc=%0d: tick=%b count=%0d done=%b want 1/1/1", k, AA_TICK[0], c0, AA_DONE[0]);
      end
    end
    mode0 = 0;
    cyc();
    checks++;
    if (c0 !== 3'd0 || AA_DONE[0] !== 1'b1) begin
      errors++;
      $display("FAIL done_sticky_loop: count=%0d done=%b want 0/1", c0, AA_DONE[0]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    spd0 = 0; lim0 = 7; mode0 = 2; AA_EN = 2'b01; CE = 1;
    spd1 = 0; lim1 = 2; mode1 = 2;
    AA_EN = 2'b11;
    for (int k = 0; k < 3; k++) cyc();
    checks++;
    if (c0 !== 3'd3 || AA_DONE[1] !== 1'b1 || AA_TICK !== 2'b11) begin
      errors++;
      $display("FAIL areset_pre: c0=%0d done1=%b tick=%b want 3/1/11", c0, AA_DONE[1], AA_TICK);
    end
    #2;
    RESETP = 0;
    #1;
    checks++;
    if (AA_COUNT !== 6'd0 || AA_TICK !== 2'b00 || AA_DONE !== 2'b00) begin
      errors++;
      $display("FAIL areset_immediate: count=%h tick=%b done=%b want 0/00/00", AA_COUNT, AA_TICK, AA_DONE);
    end
    #1;
    RESETP = 1;
    cyc();
    checks++;
    if (c0 !== 3'd1 || AA_TICK[0] !== 1'b1) begin
      errors++;
      $display("FAIL areset_first_ce: count=%0d tick=%b want 1/1", c0, AA_TICK[0]);
    end
  endtask

  initial begin
    test_reset();
    cyc();
    test_loop();
    test_pingpong();
    test_oneshot_sync();
    test_enable_freeze();
    test_limit_change();
    test_hold_sticky();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/autoanim_multi.md
Name: autoanim_multi

Overview:
- Parametrised successor to the single auto-animation timer.
- Provides CHANNELS independent animation sequencers. Each has an SPEED_W-bit period prescaler and a COUNT_W-bit tile counter.
- Counter modes: loop, ping-pong, one-shot and hold, with a programmable end value.
- Sits in the video block beside the sprite fetch logic. AA_COUNT fields replace the low tile-number bits of auto-animated sprites (one channel for fixed sprites, others for extended effects).

Parameters:
- CHANNELS, 2, number of independent animation channels (1..8)
- SPEED_W, 8, width of the per-channel period/speed value
- COUNT_W, 3, width of the per-channel tile counter (1..6)

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- RESETP  in  1  asynchronous, active-low reset
- CE  in  1  timebase enable (frame/line strobe); prescalers advance only when CE=1
- AA_EN  in  CHANNELS  per-channel enable; 0 freezes prescaler and counter
- AA_SYNC  in  CHANNELS  per-channel synchronous restart strobe
- AA_SPEED  in  CHANNELS*SPEED_W  packed period values; channel n at [n*SPEED_W +: SPEED_W]
- AA_LIMIT  in  CHANNELS*COUNT_W  packed end values; channel n at [n*COUNT_W +: COUNT_W]
- AA_MODE  in  CHANNELS*2  packed modes: 0 loop, 1 ping-pong, 2 one-shot, 3 hold
- AA_COUNT  out  CHANNELS*COUNT_W  packed registered tile counters
- AA_TICK  out  CHANNELS  registered one-clock pulse, high in the cycle the channel's counter updates
- AA_DONE  out  CHANNELS  one-shot complete flag (sticky)

Behaviour:
- Reset (RESETP=0, async) forces:
  - AA_COUNT=0, AA_TICK=0, AA_DONE=0
  - prescaler P=0
  - direction=up
- Per-channel priority each clock: AA_SYNC, then AA_EN=0, then tick logic.
- AA_SYNC=1: P<=SPEED, count<=0, dir<=up, DONE<=0, TICK<=0. This overrides CE and EN in the same cycle.
- AA_EN=0 (no sync): all channel state is held; TICK<=0.
- Prescaler with EN=1 and CE=1:
  - If P==0: tick event and P<=SPEED.
  - Otherwise P<=P-1.
- Period: SPEED+1 CE pulses per tick. SPEED=0 ticks on every CE.
- After reset, the first CE with EN=1 produces a tick.
- Tick event:
  - AA_TICK<=1 for exactly one clock.
  - The count update is registered in the same edge, so latency is 1 clock from the sampled CE.
  - No tick: AA_TICK<=0.
- Count update on tick, by mode (mode and limit are sampled at the tick):
  - Loop: count<LIMIT -> count+1; count>=LIMIT -> 0.
  - Ping-pong, dir up:
    - count<LIMIT -> count+1; if the new value equals LIMIT, dir<=down.
    - count>=LIMIT -> count<=LIMIT, dir<=down.
  - Ping-pong, dir down:
    - count>1 -> count-1.
    - count<=1 -> count<=0, dir<=up.
  - Ping-pong with LIMIT=0: count stays 0.
  - One-shot:
    - count<LIMIT -> count+1; DONE<=1 when the new value equals LIMIT.
    - count>=LIMIT -> count<=LIMIT, DONE<=1.
    - Once DONE=1, further ticks leave count unchanged. TICK still pulses.
  - Hold: count and dir unchanged; TICK still pulses; prescaler still runs.
- Arithmetic is COUNT_W-bit unsigned with no overflow past LIMIT. The maximum LIMIT (all ones) in loop mode wraps to 0.
- DONE clears only on SYNC or reset. Leaving one-shot mode does not clear it.
- A mode change mid-sequence keeps count and dir. Leaving ping-pong for loop resets dir to up at the next tick.
- Channels are fully independent. Simultaneous ticks on all channels are legal.
- Reset asserted mid-operation clears state immediately, without waiting for a clock.

Test Plan:
- Reset, then CE every clock, ch0 SPEED=3, LIMIT=7, loop -> ch0 ticks on CE 1, 5, 9, …; count goes 1,2,…,7,0,1; TICK is one clock wide.
- ch1 ping-pong, LIMIT=3, SPEED=0, CE constant -> count sequence 1,2,3,2,1,0,1,2,3.
- ch0 one-shot, LIMIT=4, SPEED=1 -> count 1..4 over ticks; DONE=1 in the same cycle count reaches 4. Count stays 4 and TICK keeps pulsing. SYNC pulse -> count=0, DONE=0, P=1.
- Edge cases:
  - EN=0 for 10 CEs mid-run -> count and P frozen; resumes the exact phase after EN=1.
  - SYNC asserted on the same clock as a tick -> count=0 and TICK=0.
- ch0 count=6 in loop, LIMIT lowered to 2 -> next tick gives count=0. Same in ping-pong -> next tick gives count=2 and dir down.
- RESETP pulled low between clock edges mid-sequence -> all outputs 0 immediately. The first CE after release ticks the count to 1.
